// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC sequencer, redirect arbiter and trap drain.
// Optional redirect/trap counters: define YSYX22040228_REDIRECT_CNT_EN.
module pc_redirect_ctrl #(
  parameter int PC_W = 64,
  parameter logic [PC_W-1:0] START_PC =
    PC_W'(64'h0000_0000_8000_0000),
  parameter int DRAIN_CYC = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_ena,
  input  logic [PC_W-1:0] trap_pc_i,
  input  logic            ex_pc_ena,
  input  logic [PC_W-1:0] ex_pc_i,
  input  logic            id_pc_ena,
  input  logic [PC_W-1:0] id_pc_i,
  input  logic [PC_W-1:0] bp_pc_i,
  input  logic            pipe_stall,
  input  logic            fetch_ready,
  output logic            pc_valid,
  output logic [PC_W-1:0] pc_o,
  output logic            flush_if,
  output logic            flush_id,
  output logic            flush_all,
  output logic [31:0]     redir_cnt_ex,
  output logic [31:0]     redir_cnt_id,
  output logic [31:0]     trap_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT =
    4'(DRAIN_CYC - 1);
  localparam logic [PC_W-1:0] ALIGN =
    {{(PC_W-1){1'b1}}, 1'b0};

  state_t state;
  state_t state_nx;

  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] tgt_nx;
  logic [3:0]      cnt;
  logic [3:0]      cnt_nx;
  logic            shadow;
  logic            shadow_nx;

  logic [PC_W-1:0] pc_nx;
  logic            valid_nx;
  logic            fif_nx;
  logic            fid_nx;
  logic            fall_nx;

  logic in_boot;
  logic in_run;
  logic in_drain;
  logic accept;
  logic id_live;
  logic sel_trap;
  logic sel_ex;
  logic sel_id;
  logic sel_acc;
  logic drain_exit;
  logic drain_stay;

  assign in_boot  = (state == BOOT);
  assign in_run   = (state == RUN);
  assign in_drain = (state == DRAIN);

  assign accept = pc_valid & fetch_ready
                & ~pipe_stall;

  // ID request behind an EX redirect or trap
  // return is on the wrong path.
  assign id_live = id_pc_ena & ~shadow;

  // One-hot selects: first match wins.
  assign sel_trap = in_run & trap_ena;
  assign sel_ex   = in_run & ~trap_ena
                  & ex_pc_ena;
  assign sel_id   = in_run & ~trap_ena
                  & ~ex_pc_ena & id_live;
  assign sel_acc  = in_run & ~trap_ena
                  & ~ex_pc_ena & ~id_live
                  & accept;

  assign drain_exit = in_drain
                    & (cnt == 4'd0);
  assign drain_stay = in_drain
                    & (cnt != 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT:    state_nx = RUN;
      RUN:     if (trap_ena) state_nx = DRAIN;
      DRAIN:   if (cnt == 4'd0) state_nx = RUN;
      default: state_nx = BOOT;
    endcase
  end

  always_comb begin
    pc_nx     = pc_o;
    valid_nx  = pc_valid;
    fif_nx    = 1'b0;
    fid_nx    = 1'b0;
    fall_nx   = 1'b0;
    shadow_nx = 1'b0;
    tgt_nx    = tgt;
    cnt_nx    = cnt;
    unique case (1'b1)
      in_boot: begin
        pc_nx    = START_PC;
        valid_nx = 1'b1;
      end
      sel_trap: begin
        tgt_nx   = trap_pc_i & ALIGN;
        cnt_nx   = CNT_INIT;
        valid_nx = 1'b0;
        fall_nx  = 1'b1;
      end
      sel_ex: begin
        pc_nx     = ex_pc_i & ALIGN;
        valid_nx  = 1'b1;
        fif_nx    = 1'b1;
        fid_nx    = 1'b1;
        shadow_nx = 1'b1;
      end
      sel_id: begin
        pc_nx  = id_pc_i & ALIGN;
        fif_nx = 1'b1;
      end
      sel_acc: begin
        pc_nx = bp_pc_i & ALIGN;
      end
      drain_stay: begin
        valid_nx = 1'b0;
        fall_nx  = 1'b1;
        cnt_nx   = cnt - 4'd1;
        if (trap_ena) begin
          tgt_nx = trap_pc_i & ALIGN;
        end
      end
      drain_exit: begin
        // A re-trap on the last drain cycle
        // still wins over the older target.
        pc_nx     = trap_ena
                  ? (trap_pc_i & ALIGN)
                  : tgt;
        tgt_nx    = pc_nx;
        valid_nx  = 1'b1;
        shadow_nx = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_o      <= START_PC;
      pc_valid  <= 1'b0;
      flush_if  <= 1'b0;
      flush_id  <= 1'b0;
      flush_all <= 1'b0;
      shadow    <= 1'b0;
      tgt       <= '0;
      cnt       <= '0;
    end else begin
      pc_o      <= pc_nx;
      pc_valid  <= valid_nx;
      flush_if  <= fif_nx;
      flush_id  <= fid_nx;
      flush_all <= fall_nx;
      shadow    <= shadow_nx;
      tgt       <= tgt_nx;
      cnt       <= cnt_nx;
    end
  end

`ifdef YSYX22040228_REDIRECT_CNT_EN
  logic [31:0] cnt_ex_q;
  logic [31:0] cnt_id_q;
  logic [31:0] cnt_tr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_ex_q <= '0;
      cnt_id_q <= '0;
      cnt_tr_q <= '0;
    end else begin
      if (sel_ex && (cnt_ex_q != '1)) begin
        cnt_ex_q <= cnt_ex_q + 32'd1;
      end
      if (sel_id && (cnt_id_q != '1)) begin
        cnt_id_q <= cnt_id_q + 32'd1;
      end
      if (sel_trap && (cnt_tr_q != '1)) begin
        cnt_tr_q <= cnt_tr_q + 32'd1;
      end
    end
  end

  assign redir_cnt_ex = cnt_ex_q;
  assign redir_cnt_id = cnt_id_q;
  assign trap_cnt     = cnt_tr_q;
`else
  assign redir_cnt_ex = '0;
  assign redir_cnt_id = '0;
  assign trap_cnt     = '0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed scoreboard bench
// for the fetch PC sequencer and redirect arbiter.
module tb_pc_redirect_ctrl;

  typedef struct {
    string       tag;
    logic        v;
    logic [63:0] pc;
    logic        fi;
    logic        fd;
    logic        fa;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        trap_ena;
  logic [63:0] trap_pc_i;
  logic        ex_pc_ena;
  logic [63:0] ex_pc_i;
  logic        id_pc_ena;
  logic [63:0] id_pc_i;
  logic [63:0] bp_pc_i;
  logic        pipe_stall;
  logic        fetch_ready;
  logic        pc_valid;
  logic [63:0] pc_o;
  logic        flush_if;
  logic        flush_id;
  logic        flush_all;
  logic [31:0] redir_cnt_ex;
  logic [31:0] redir_cnt_id;
  logic [31:0] trap_cnt;

  exp_t sb[$];
  int   n_chk;
  int   n_pass;

  pc_redirect_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .trap_ena     (trap_ena),
    .trap_pc_i    (trap_pc_i),
    .ex_pc_ena    (ex_pc_ena),
    .ex_pc_i      (ex_pc_i),
    .id_pc_ena    (id_pc_ena),
    .id_pc_i      (id_pc_i),
    .bp_pc_i      (bp_pc_i),
    .pipe_stall   (pipe_stall),
    .fetch_ready  (fetch_ready),
    .pc_valid     (pc_valid),
    .pc_o         (pc_o),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .flush_all    (flush_all),
    .redir_cnt_ex (redir_cnt_ex),
    .redir_cnt_id (redir_cnt_id),
    .trap_cnt     (trap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sequential predictor: next PC is pc_o + 4.
  assign bp_pc_i = pc_o + 64'd4;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Push the expectation for the next edge,
  // then pop it once the DUT has updated.
  task automatic step(
    input string       tag,
    input logic        v,
    input logic [63:0] pc,
    input logic        fi,
    input logic        fd,
    input logic        fa
  );
    exp_t e;
    sb.push_back('{tag, v, pc, fi, fd, fa});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, ".valid"},
          64'(pc_valid), 64'(e.v));
    if (e.v) begin
      check({e.tag, ".pc"}, pc_o, e.pc);
    end
    check({e.tag, ".fif"},
          64'(flush_if), 64'(e.fi));
    check({e.tag, ".fid"},
          64'(flush_id), 64'(e.fd));
    check({e.tag, ".fall"},
          64'(flush_all), 64'(e.fa));
  endtask

  localparam logic [63:0] B = 64'h8000_0000;

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    rst         = 1'b1;
    trap_ena    = 1'b0;
    trap_pc_i   = '0;
    ex_pc_ena   = 1'b0;
    ex_pc_i     = '0;
    id_pc_ena   = 1'b0;
    id_pc_i     = '0;
    pipe_stall  = 1'b0;
    fetch_ready = 1'b1;

    @(posedge clk);
    #1;
    step("rst", 0, B, 0, 0, 0);
    check("rst.pc", pc_o, B);
    check("rst.cex", 64'(redir_cnt_ex), 0);

    rst = 1'b0;
    step("boot", 1, B, 0, 0, 0);
    step("seq1", 1, B + 4, 0, 0, 0);
    step("seq2", 1, B + 8, 0, 0, 0);
    fetch_ready = 1'b0;
    step("nordy", 1, B + 8, 0, 0, 0);
    fetch_ready = 1'b1;
    step("seq3", 1, B + 12, 0, 0, 0);

    ex_pc_ena = 1'b1;
    ex_pc_i   = B + 64'h100;
    id_pc_ena = 1'b1;
    id_pc_i   = B + 64'h200;
    step("exid", 1, B + 64'h100, 1, 1, 0);
    ex_pc_ena = 1'b0;
    id_pc_i   = B + 64'h300;
    step("shad", 1, B + 64'h104, 0, 0, 0);
    id_pc_ena = 1'b0;
    step("post", 1, B + 64'h108, 0, 0, 0);

    pipe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, B + 64'h108, 0, 0, 0);
    end
    ex_pc_ena = 1'b1;
    ex_pc_i   = B + 64'h41;
    step("stex", 1, B + 64'h40, 1, 1, 0);
    ex_pc_ena  = 1'b0;
    pipe_stall = 1'b0;
    step("stex2", 1, B + 64'h44, 0, 0, 0);

    trap_ena  = 1'b1;
    trap_pc_i = B + 64'h1000;
    step("tr1", 0, 0, 0, 0, 1);
    trap_ena  = 1'b0;
    ex_pc_ena = 1'b1;
    ex_pc_i   = B + 64'h5000;
    step("tr2", 0, 0, 0, 0, 1);
    ex_pc_ena = 1'b0;
    step("tr3", 0, 0, 0, 0, 1);
    step("trx", 1, B + 64'h1000, 0, 0, 0);
    step("trn", 1, B + 64'h1004, 0, 0, 0);

`ifdef YSYX22040228_REDIRECT_CNT_EN
    check("cnt.ex", 64'(redir_cnt_ex), 2);
    check("cnt.id", 64'(redir_cnt_id), 0);
    check("cnt.tr", 64'(trap_cnt), 1);
`else
    check("cnt.ex", 64'(redir_cnt_ex), 0);
    check("cnt.id", 64'(redir_cnt_id), 0);
    check("cnt.tr", 64'(trap_cnt), 0);
`endif

    trap_ena  = 1'b1;
    trap_pc_i = B + 64'h3000;
    step("rt1", 0, 0, 0, 0, 1);
    trap_ena = 1'b0;
    step("rt2", 0, 0, 0, 0, 1);
    trap_ena  = 1'b1;
    trap_pc_i = B + 64'h2001;
    step("rt3", 0, 0, 0, 0, 1);
    trap_ena = 1'b0;
    step("rtx", 1, B + 64'h2000, 0, 0, 0);

    id_pc_ena = 1'b1;
    id_pc_i   = B + 64'h601;
    step("xshd", 1, B + 64'h2004, 0, 0, 0);
    id_pc_i = B + 64'h401;
    step("id1", 1, B + 64'h400, 1, 0, 0);
    id_pc_i = B + 64'h501;
    step("id2", 1, B + 64'h500, 1, 0, 0);
    id_pc_ena = 1'b0;
    step("id3", 1, B + 64'h504, 0, 0, 0);

    trap_ena  = 1'b1;
    trap_pc_i = B + 64'h7000;
    step("mt1", 0, 0, 0, 0, 1);
    trap_ena = 1'b0;
    rst      = 1'b1;
    step("mrst", 0, 0, 0, 0, 0);
    check("mrst.pc", pc_o, B);
    check("mrst.cid", 64'(redir_cnt_id), 0);
    check("mrst.ctr", 64'(trap_cnt), 0);
    rst = 1'b0;
    step("mboot", 1, B, 0, 0, 0);
    step("mseq", 1, B + 4, 0, 0, 0);

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end

endmodule
